// File: rtl/hs4_pkg.sv
// Shared types and helpers for the four-phase link endpoints.
package hs4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs4_state_e;

  localparam int B_DEF = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hs4_sync.sv
// Single-bit multi-flop synchroniser with synchronous active-high reset.
module hs4_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs4_receiver.sv
// Four-phase req/ack receiver with show-ahead receive FIFO.
// Optional statistics (rx_count, stall_seen) enabled by macro HS4_RX_STATS_EN.
module hs4_receiver
  import hs4_pkg::*;
#(
  parameter int B           = B_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_in,
  input  logic [B-1:0] data_in,
  output logic         ack_out,
  output logic [B-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef HS4_RX_STATS_EN
  ,
  output logic [31:0]  rx_count,
  output logic         stall_seen
`endif
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          req_s;
  hs4_state_e    state_q;
  logic          ack_q;
  logic [B-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, pop;

  hs4_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (req_in),
    .q_o (req_s)
  );

  // Full check uses the pre-edge count, so a same-cycle pop never frees room for a push.
  assign full = (count_q == FULL);
  assign push = (state_q == IDLE) && req_s && !full;
  assign pop  = (count_q != '0) && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO masks its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign ack_out   = ack_q;
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef HS4_RX_STATS_EN
  logic [31:0] rx_count_q;
  logic        stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (push) rx_count_q <= rx_count_q + 32'd1;
      if ((state_q == IDLE) && req_s && full) stall_q <= 1'b1;
    end
  end

  assign rx_count   = rx_count_q;
  assign stall_seen = stall_q;
`endif

endmodule

// File: tb/tb_hs4_receiver.sv
// Self-checking bench for hs4_receiver: cycle table, directed corner sequences, random traffic.
module tb_hs4_receiver;

  localparam int B     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_in;
  logic [B-1:0] data_in;
  logic         ack_out;
  logic [B-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
`ifdef HS4_RX_STATS_EN
  logic [31:0]  rx_count;
  logic         stall_seen;
`endif

  hs4_receiver #(.B(B), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef HS4_RX_STATS_EN
    ,
    .rx_count  (rx_count),
    .stall_seen(stall_seen)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [B-1:0] exp_q [$];
  bit mon_en   = 1'b0;
  bit done     = 1'b0;

  typedef struct {
    logic         req;
    logic         rdy;
    logic [B-1:0] din;
    logic         ack;
    logic         vld;
    logic [B-1:0] dout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Consumer-side scoreboard: words must leave in send order, none lost, none duplicated.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_with_empty_model", out_valid, 1'b0);
        else                   check("pop_data", out_data, exp_q.pop_front());
      end else begin
        check("valid_vs_model", out_valid, exp_q.size() != 0);
      end
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    tick;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [B-1:0] w, input int budget);
    bit got;
    data_in = w;
    req_in  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick;
      if (ack_out) got = 1'b1;
    end
    check("ack_rise", got, 1'b1);
    if (got) exp_q.push_back(w);
    req_in  = 1'b0;
    data_in = B'($urandom);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick;
      if (!ack_out) got = 1'b1;
    end
    check("ack_fall", got, 1'b1);
  endtask

  task automatic wait_empty(input int budget);
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < budget && !empty; i++) begin
      tick;
      if (exp_q.size() == 0 && !out_valid) empty = 1'b1;
    end
    check("drain_complete", empty, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    bit   flag;

    rst = 1'b1; req_in = 1'b0; data_in = '0; out_ready = 1'b0;
    tick; tick;
    check("rst_ack", ack_out, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 16'h0);
`ifdef HS4_RX_STATS_EN
    check("rst_rx_count", rx_count, 32'd0);
    check("rst_stall", stall_seen, 1'b0);
`endif
    rst = 1'b0;

    // Single transfer, one row per clock: inputs before the edge, outputs after it.
    tbl[0] = '{1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b1, 16'hA5A5};
    tbl[3] = '{1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000};
    tbl[5] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000};
    tbl[7] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      req_in = tbl[i].req; out_ready = tbl[i].rdy; data_in = tbl[i].din;
      tick;
      check($sformatf("tbl%0d_ack", i), ack_out, tbl[i].ack);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].vld);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].dout);
    end

    // Five transfers into a four-deep FIFO with the consumer stalled.
    do_reset;
    mon_en = 1'b1;
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) send_word(B'(w), 20);
    data_in = 16'd5; req_in = 1'b1;
    flag = 1'b0;
    repeat (10) begin
      tick;
      if (ack_out) flag = 1'b1;
    end
    check("full_ack_held_low", flag, 1'b0);
    check("full_head_word", out_data, 16'd1);
`ifdef HS4_RX_STATS_EN
    check("stall_seen_set", stall_seen, 1'b1);
    check("rx_count_4", rx_count, 32'd4);
`endif
    out_ready = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 30 && !flag; i++) begin
      tick;
      if (ack_out) flag = 1'b1;
    end
    check("fifth_acked", flag, 1'b1);
    if (flag) exp_q.push_back(16'd5);
    req_in = 1'b0;
    repeat (4) tick;
    check("fifth_ack_fall", ack_out, 1'b0);
    wait_empty(20);
`ifdef HS4_RX_STATS_EN
    check("stall_seen_sticky", stall_seen, 1'b1);
    check("rx_count_5", rx_count, 32'd5);
`endif

    // Wrap-around with the consumer toggling ready every cycle.
    done = 1'b0;
    fork
      begin
        while (!done) begin
          out_ready = ~out_ready;
          tick;
        end
      end
      begin
        for (int w = 16'h10; w <= 16'h19; w++) send_word(B'(w), 30);
        done = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_empty(30);

    // Sender holds req for 20 cycles after ack: one word only, ack falls 3 edges after req drops.
    out_ready = 1'b0;
    data_in = 16'hBEEF; req_in = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 10 && !flag; i++) begin
      tick;
      if (ack_out) flag = 1'b1;
    end
    check("hold_ack_rise", flag, 1'b1);
    if (flag) exp_q.push_back(16'hBEEF);
    flag = 1'b1;
    repeat (20) begin
      tick;
      data_in = B'($urandom);
      if (!ack_out) flag = 1'b0;
    end
    check("hold_ack_stays_high", flag, 1'b1);
    check("hold_head_word", out_data, 16'hBEEF);
    req_in = 1'b0;
    tick; check("hold_fall_edge1", ack_out, 1'b1);
    tick; check("hold_fall_edge2", ack_out, 1'b1);
    tick; check("hold_fall_edge3", ack_out, 1'b0);
    out_ready = 1'b1;
    wait_empty(10);
    repeat (3) tick;

    // Reset while in ACK with two words stored; held req is recaptured afterwards.
    out_ready = 1'b0;
    send_word(16'h0011, 20);
    data_in = 16'h0022; req_in = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 10 && !flag; i++) begin
      tick;
      if (ack_out) flag = 1'b1;
    end
    check("pre_rst_ack", flag, 1'b1);
    if (flag) exp_q.push_back(16'h0022);
    rst = 1'b1;
    tick;
    check("mid_rst_ack", ack_out, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 16'h0);
    exp_q.delete();
    rst = 1'b0;
    tick; check("recap_edge1", ack_out, 1'b0);
    tick; check("recap_edge2", ack_out, 1'b0);
    tick; check("recap_edge3", ack_out, 1'b1);
    if (ack_out) exp_q.push_back(16'h0022);
    check("recap_data", out_data, 16'h0022);
    req_in = 1'b0;
    repeat (4) tick;
    out_ready = 1'b1;
    wait_empty(10);

    // Random traffic against the in-order scoreboard.
    done = 1'b0;
    fork
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick;
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) tick;
          send_word(B'($urandom), 60);
        end
        done = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_empty(50);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
